// File: rtl/stopwatch_core_pkg.sv
// Shared types and BCD limits for the stopwatch core.
package stopwatch_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2,
    ST_LAP     = 2'd3
  } sw_state_e;

  localparam int unsigned NUM_DIGITS = 5;

  localparam logic [3:0] BCD_MAX_UNITS    = 4'd9;
  localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;
  localparam logic [3:0] BCD_MAX_MINUTE   = 4'd9;

  // Digit order, LSB first: hundredths units, hundredths tens, seconds units,
  // seconds tens, minute.
  localparam logic [NUM_DIGITS-1:0][3:0] DIGIT_MAX = {
    BCD_MAX_MINUTE, BCD_MAX_SEC_TENS, BCD_MAX_UNITS, BCD_MAX_UNITS, BCD_MAX_UNITS
  };

endpackage

// File: rtl/stopwatch_core_bcd_digit_counter.sv
// One BCD digit that rolls over at MAX; exposes its next value for snapshotting.
module bcd_digit_counter #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] value,
  output logic [3:0] value_nxt,
  output logic       carry
);

  assign carry = enable && (value == MAX);

  always_comb begin
    value_nxt = value;
    if (clear)       value_nxt = 4'd0;
    else if (enable) value_nxt = (value == MAX) ? 4'd0 : value + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) value <= 4'd0;
    else       value <= value_nxt;
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch: key edge detect, run/stop/lap FSM, 5-digit BCD count, lap hold.
module stopwatch_core
  import stopwatch_core_pkg::*;
#(
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_start,
  input  logic       key_lap,
  input  logic       key_clear,
  output logic [3:0] minute,
  output logic [7:0] second,
  output logic [7:0] m_second,
  output logic       running,
  output logic       overflow
);

  if (TICK_HZ <= 0) begin : g_bad_tick_hz
    $error("TICK_HZ must be positive");
  end

  sw_state_e state_q, state_d;
  logic      start_q, lap_q, clear_q;
  logic      start_ev, lap_ev, clear_ev;
  logic      cnt_en, wrap;

  logic [NUM_DIGITS-1:0][3:0] live, live_nxt, lap_reg, disp;
  logic [NUM_DIGITS-1:0]      dig_en, dig_carry;

  assign start_ev = key_start & ~start_q;
  assign lap_ev   = key_lap   & ~lap_q;
  assign clear_ev = key_clear & ~clear_q;

  assign running = (state_q == ST_RUN) || (state_q == ST_LAP);
  // Count decision uses the pre-edge state; clear swallows a coincident tick.
  assign cnt_en  = tick && running && !clear_ev;

  assign dig_en = {dig_carry[NUM_DIGITS-2:0], cnt_en};
  assign wrap   = dig_carry[NUM_DIGITS-1];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_counter #(.MAX(DIGIT_MAX[i])) u_digit (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear_ev),
      .enable    (dig_en[i]),
      .value     (live[i]),
      .value_nxt (live_nxt[i]),
      .carry     (dig_carry[i])
    );
  end

  always_comb begin
    state_d = state_q;
    if (clear_ev) begin
      state_d = ST_IDLE;
    end else if (start_ev) begin
      unique case (state_q)
        ST_IDLE:    state_d = ST_RUN;
        ST_RUN:     state_d = ST_STOPPED;
        ST_STOPPED: state_d = ST_RUN;
        ST_LAP:     state_d = ST_STOPPED;
        default:    state_d = ST_IDLE;
      endcase
    end else if (lap_ev) begin
      if (state_q == ST_RUN)      state_d = ST_LAP;
      else if (state_q == ST_LAP) state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      lap_q    <= 1'b0;
      clear_q  <= 1'b0;
      lap_reg  <= '0;
      disp     <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= key_start;
      lap_q   <= key_lap;
      clear_q <= key_clear;

      if (clear_ev)
        lap_reg <= '0;
      else if (state_q == ST_RUN && state_d == ST_LAP)
        lap_reg <= live_nxt;

      if (clear_ev)  overflow <= 1'b0;
      else if (wrap) overflow <= 1'b1;

      disp <= (state_q == ST_LAP) ? lap_reg : live;
    end
  end

  assign minute   = disp[4];
  assign second   = {disp[3], disp[2]};
  assign m_second = {disp[1], disp[0]};

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with hand-computed expected displays.
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       reset, tick, key_start, key_lap, key_clear;
  logic [3:0] minute;
  logic [7:0] second, m_second;
  logic       running, overflow;

  int vectors = 0;
  int miscompares = 0;

  stopwatch_core #(.TICK_HZ(100)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .key_start (key_start),
    .key_lap   (key_lap),
    .key_clear (key_clear),
    .minute    (minute),
    .second    (second),
    .m_second  (m_second),
    .running   (running),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [3:0] m, input logic [7:0] s,
                          input logic [7:0] h);
    chk({tag, ".minute"},   {28'd0, minute}, {28'd0, m});
    chk({tag, ".second"},   {24'd0, second}, {24'd0, s});
    chk({tag, ".m_second"}, {24'd0, m_second}, {24'd0, h});
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; key_start = 1'b0; key_lap = 1'b0; key_clear = 1'b0;
    cyc(2);
    reset = 1'b0;
    chk_time("reset", 4'h0, 8'h00, 8'h00);
    chk("reset.running", {31'd0, running}, 32'd0);
    chk("reset.overflow", {31'd0, overflow}, 32'd0);

    // start, 150 ticks -> 0:01.50
    key_start = 1'b1; cyc(1); key_start = 1'b0;
    tick = 1'b1; cyc(150); tick = 1'b0; cyc(1);
    chk_time("run150", 4'h0, 8'h01, 8'h50);
    chk("run150.running", {31'd0, running}, 32'd1);

    // stop freezes the count
    key_start = 1'b1; cyc(1); key_start = 1'b0;
    tick = 1'b1; cyc(10); tick = 1'b0; cyc(1);
    chk_time("stopped", 4'h0, 8'h01, 8'h50);
    chk("stopped.running", {31'd0, running}, 32'd0);

    key_clear = 1'b1; cyc(1); key_clear = 1'b0; cyc(1);
    chk_time("clear1", 4'h0, 8'h00, 8'h00);
    chk("clear1.running", {31'd0, running}, 32'd0);

    // start with coincident tick is not counted; stop with coincident tick is
    key_start = 1'b1; tick = 1'b1; cyc(1);
    key_start = 1'b0; tick = 1'b0; cyc(1);
    chk_time("start_tick", 4'h0, 8'h00, 8'h00);
    key_start = 1'b1; tick = 1'b1; cyc(1);
    key_start = 1'b0; cyc(5); tick = 1'b0; cyc(1);
    chk_time("stop_tick", 4'h0, 8'h00, 8'h01);
    chk("stop_tick.running", {31'd0, running}, 32'd0);

    key_clear = 1'b1; cyc(1); key_clear = 1'b0; cyc(1);

    // lap holds 0:05.00 while live advances to 0:08.00
    key_start = 1'b1; cyc(1); key_start = 1'b0;
    tick = 1'b1; cyc(500); tick = 1'b0;
    key_lap = 1'b1; cyc(1); key_lap = 1'b0;
    tick = 1'b1; cyc(300); tick = 1'b0; cyc(1);
    chk_time("lap_hold", 4'h0, 8'h05, 8'h00);
    chk("lap_hold.running", {31'd0, running}, 32'd1);
    key_lap = 1'b1; cyc(1); key_lap = 1'b0; cyc(1);
    chk_time("lap_release", 4'h0, 8'h08, 8'h00);

    // clear beats start on the same edge, coincident tick dropped
    key_clear = 1'b1; cyc(1); key_clear = 1'b0;
    key_start = 1'b1; cyc(1); key_start = 1'b0;
    tick = 1'b1; cyc(100); tick = 1'b0; cyc(1);
    chk_time("pre_prio", 4'h0, 8'h01, 8'h00);
    key_start = 1'b1; key_clear = 1'b1; tick = 1'b1; cyc(1);
    key_start = 1'b0; key_clear = 1'b0; tick = 1'b0; cyc(1);
    chk_time("prio", 4'h0, 8'h00, 8'h00);
    chk("prio.running", {31'd0, running}, 32'd0);

    // run up to 9:59.98, then wrap
    key_start = 1'b1; cyc(1); key_start = 1'b0;
    tick = 1'b1; cyc(59998); tick = 1'b0; cyc(1);
    chk_time("max", 4'h9, 8'h59, 8'h98);
    chk("max.overflow", {31'd0, overflow}, 32'd0);
    tick = 1'b1; cyc(2); tick = 1'b0; cyc(1);
    chk_time("wrap", 4'h0, 8'h00, 8'h00);
    chk("wrap.overflow", {31'd0, overflow}, 32'd1);
    chk("wrap.running", {31'd0, running}, 32'd1);
    tick = 1'b1; cyc(3); tick = 1'b0; cyc(1);
    chk_time("post_wrap", 4'h0, 8'h00, 8'h03);
    chk("post_wrap.overflow", {31'd0, overflow}, 32'd1);
    key_clear = 1'b1; cyc(1); key_clear = 1'b0; cyc(1);
    chk("wrap_clear.overflow", {31'd0, overflow}, 32'd0);
    chk("wrap_clear.running", {31'd0, running}, 32'd0);
    chk_time("wrap_clear", 4'h0, 8'h00, 8'h00);

    // lap in IDLE is ignored
    key_lap = 1'b1; cyc(1); key_lap = 1'b0; cyc(1);
    chk("idle_lap.running", {31'd0, running}, 32'd0);

    // held start key is a single event
    key_start = 1'b1; cyc(50);
    chk("held_start.running", {31'd0, running}, 32'd1);
    key_start = 1'b0;
    tick = 1'b1; cyc(20); tick = 1'b0; cyc(1);
    chk_time("held_run", 4'h0, 8'h00, 8'h20);

    // reset mid-run
    tick = 1'b1; reset = 1'b1; key_start = 1'b1; cyc(1);
    chk_time("mid_reset", 4'h0, 8'h00, 8'h00);
    chk("mid_reset.running", {31'd0, running}, 32'd0);
    chk("mid_reset.overflow", {31'd0, overflow}, 32'd0);
    reset = 1'b0; key_start = 1'b0;
    cyc(3); tick = 1'b0; cyc(1);
    chk_time("after_reset", 4'h0, 8'h00, 8'h00);
    chk("after_reset.running", {31'd0, running}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 SHALL have parameter TICK_HZ, default 100, meaning the nominal rate of the tick input; it is documentation only and SHALL NOT alter behaviour.
REQ-002 SHALL have port clk, input, 1 bit: the single clock.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port tick, input, 1 bit: single-cycle 1/100 s enable pulse.
REQ-005 SHALL have port key_start, input, 1 bit: debounced, synchronized start/stop level.
REQ-006 SHALL have port key_lap, input, 1 bit: debounced, synchronized lap level.
REQ-007 SHALL have port key_clear, input, 1 bit: debounced, synchronized clear level.
REQ-008 SHALL have port minute, output, 4 bits: BCD minutes, 0-9.
REQ-009 SHALL have port second, output, 8 bits: two BCD digits, tens in [7:4], 00-59.
REQ-010 SHALL have port m_second, output, 8 bits: two BCD digits of hundredths, 00-99.
REQ-011 SHALL have port running, output, 1 bit: high when the state is RUN or LAP.
REQ-012 SHALL have port overflow, output, 1 bit: sticky flag for a wrap past 9:59.99.

Function
REQ-013 SHALL detect a key event when the key is 1 this cycle and its registered previous sample is 0; the FSM acts at that same clock edge, with no extra latency.
REQ-014 SHALL implement states IDLE, RUN, STOPPED and LAP.
REQ-015 Transitions SHALL be:
- IDLE --start--> RUN
- RUN --start--> STOPPED
- STOPPED --start--> RUN
- RUN --lap--> LAP
- LAP --lap--> RUN
- LAP --start--> STOPPED
- any state --clear--> IDLE
- lap in IDLE or STOPPED: ignored
REQ-016 Simultaneous key events SHALL be prioritised clear > start > lap; the lower-priority events in that cycle are discarded.
REQ-017 The live count SHALL increment by one hundredth on tick only when the state before the edge is RUN or LAP. A tick coincident with a start from IDLE or STOPPED is not counted; a tick coincident with a stop is counted.
REQ-018 Increment carry chain: hundredths units 9->0 carries to hundredths tens; hundredths 99->00 carries to seconds units; seconds 59->00 carries to minute; minute 9->0 is the wrap.
REQ-019 On wrap, 9:59.99 plus a tick SHALL produce 0:00.00 and set overflow, which stays set until clear or reset; counting continues.
REQ-020 Clear SHALL zero the live count, lap register and overflow at that edge; a coincident tick is ignored.
REQ-021 Outputs minute/second/m_second SHALL be registered.
- In IDLE, RUN and STOPPED they equal the live count one cycle after it updates.
- On entry to LAP, the lap register captures the post-increment live count of that edge; outputs show the lap register while in LAP.
- On leaving LAP, outputs return to the live count.
REQ-022 BCD digits SHALL never take values A-F; the seconds tens digit SHALL never exceed 5.

Reset
REQ-023 Reset SHALL force state IDLE, all count and lap digits to 0, the key history registers to 0, and outputs minute=0, second=8'h00, m_second=8'h00, running=0, overflow=0.
REQ-024 Reset SHALL override every key and tick in the same cycle.
REQ-025 Reset mid-RUN SHALL take effect at the next edge with no residual count.

Structure
REQ-026 A shared package SHALL hold the state encoding (2-bit enum) and the BCD limit constants (9, 5, 9).
REQ-027 One sub-module, bcd_digit_counter, SHALL be provided: parameter MAX, ports enable/clear, carry-out asserted when enable and the value equals MAX. stopwatch_core instantiates five of them.

Verification
REQ-028 Reset, then start, then 150 ticks -> minute=0, second=8'h01, m_second=8'h50, running=1.
REQ-029 Preload 9:59.98 in RUN, then 2 ticks -> 0:00.00 with overflow=1; then clear -> overflow=0 and state IDLE.
REQ-030 RUN at 0:05.00, lap, then 300 ticks -> outputs hold 0:05.00; lap again -> outputs 0:08.00.
REQ-031 key_start and key_clear rising in the same cycle as a tick while in RUN at 0:01.00 -> IDLE, outputs 0:00.00, running=0.
REQ-032 Start from IDLE coincident with a tick -> count remains 0:00.00; then stop coincident with the next tick -> 0:00.01 frozen in STOPPED.
REQ-033 key_start held high for 50 cycles -> exactly one transition; reset asserted mid-RUN -> all outputs 0 on the next cycle.
